ps2_key_event_rx: RTL and testbench

Parametrised PS/2 keyboard receiver that replaces the fixed 4-state-divider scanner/driver pair with a single clock-domain block. It filters the PS/2 lines, checks full 11-bit frames (start, odd parity, stop), and folds E0 (extended) and F0 (break) prefixes into one event per key action. It buffers events in a show-ahead FIFO with a valid/ready handshake and decodes the head event to a 4-bit digit/control code for the CPU's keyboard MMIO port.

---
 rtl/ps2_key_event_rx.sv | 242 ++++++++++++++++++++++++
 tb/tb_ps2_key_event_rx.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_event_rx.sv
// PS/2 keyboard receiver: line filtering, 11-bit frame checking, E0/F0 prefix folding,
// show-ahead event FIFO and digit/control decode of the head event.
module ps2_key_event_rx #(
    parameter int CLK_DIV     = 4,
    parameter int FILTER_LEN  = 8,
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ps2_clk,
    input  logic                        ps2_data,
    output logic                        key_valid,
    input  logic                        key_ready,
    output logic [7:0]                  key_code,
    output logic                        key_ext,
    output logic                        key_break,
    output logic [3:0]                  key_digit,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        frame_err,
    output logic                        overflow
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} frame_state_t;

    logic [1:0]            clk_s, dat_s;
    logic [DIV_W-1:0]      div_cnt;
    logic                  tick;
    logic [FILTER_LEN-1:0] clk_sr, dat_sr;
    logic                  clk_f, dat_f, clk_f_d, fall;
    frame_state_t          state, state_nx;
    logic [7:0]            sh;
    logic [2:0]            bit_cnt;
    logic                  par_bit;
    logic [TO_W-1:0]       to_cnt;
    logic                  to_hit;
    logic                  byte_done_c, err_c;
    logic                  byte_done_q, frame_err_q;
    logic [7:0]            byte_q;
    logic                  ext_f, brk_f;
    logic                  push, pop, wr, full;
    logic [9:0]            mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic                  ovf_q;
    logic [9:0]            head;

    // Two-flop synchronisers; idle-high lines so reset value is 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s <= 2'b11;
            dat_s <= 2'b11;
        end else begin
            clk_s <= {clk_s[0], ps2_clk};
            dat_s <= {dat_s[0], ps2_data};
        end
    end

    assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst)       div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + DIV_W'(1);
    end

    // Glitch filter: level only changes once the whole window agrees.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sr  <= '1;
            dat_sr  <= '1;
            clk_f   <= 1'b1;
            dat_f   <= 1'b1;
            clk_f_d <= 1'b1;
            fall    <= 1'b0;
        end else begin
            if (tick) begin
                clk_sr <= {clk_sr[FILTER_LEN-2:0], clk_s[1]};
                dat_sr <= {dat_sr[FILTER_LEN-2:0], dat_s[1]};
            end
            if (&clk_sr)       clk_f <= 1'b1;
            else if (~|clk_sr) clk_f <= 1'b0;
            if (&dat_sr)       dat_f <= 1'b1;
            else if (~|dat_sr) dat_f <= 1'b0;
            clk_f_d <= clk_f;
            fall    <= clk_f_d & ~clk_f;
        end
    end

    assign to_hit = (state != S_IDLE) && !fall && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (to_hit) begin
            state_nx = S_IDLE;
        end else if (fall) begin
            case (state)
                S_IDLE:   if (!dat_f) state_nx = S_DATA;
                S_DATA:   if (bit_cnt == 3'd7) state_nx = S_PARITY;
                S_PARITY: state_nx = S_STOP;
                default:  state_nx = S_IDLE;
            endcase
        end
    end

    always_comb begin
        byte_done_c = 1'b0;
        err_c       = to_hit;
        if (fall) begin
            if (state == S_IDLE && dat_f) err_c = 1'b1;
            if (state == S_STOP) begin
                if (dat_f && (^{sh, par_bit})) byte_done_c = 1'b1;
                else                           err_c       = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh      <= '0;
            bit_cnt <= '0;
            par_bit <= 1'b0;
        end else if (fall) begin
            case (state)
                S_IDLE:   bit_cnt <= '0;
                S_DATA: begin
                    sh      <= {dat_f, sh[7:1]};
                    bit_cnt <= bit_cnt + 3'd1;
                end
                S_PARITY: par_bit <= dat_f;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                          to_cnt <= '0;
        else if (state == S_IDLE || fall) to_cnt <= '0;
        else if (!to_hit)                 to_cnt <= to_cnt + TO_W'(1);
        else                              to_cnt <= '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_done_q <= 1'b0;
            frame_err_q <= 1'b0;
            byte_q      <= '0;
        end else begin
            byte_done_q <= byte_done_c;
            frame_err_q <= err_c;
            if (byte_done_c) byte_q <= sh;
        end
    end

    // Prefix bytes only set flags; the next ordinary byte carries them as one event.
    always_ff @(posedge clk) begin
        if (rst || frame_err_q) begin
            ext_f <= 1'b0;
            brk_f <= 1'b0;
        end else if (byte_done_q) begin
            if (byte_q == 8'hE0)      ext_f <= 1'b1;
            else if (byte_q == 8'hF0) brk_f <= 1'b1;
            else begin
                ext_f <= 1'b0;
                brk_f <= 1'b0;
            end
        end
    end

    // Handshake: the head event is transferred on any cycle where key_valid and
    // key_ready are both high; key_ready has no effect while key_valid is low.
    assign push = byte_done_q && (byte_q != 8'hE0) && (byte_q != 8'hF0);
    assign full = (fifo_count == (AW + 1)'(FIFO_DEPTH));
    assign pop  = key_valid && key_ready;
    assign wr   = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= {ext_f, brk_f, byte_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            ovf_q      <= 1'b0;
        end else begin
            if (wr)  wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({wr, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: ;
            endcase
            ovf_q <= push && full && !pop;
        end
    end

    function automatic logic [3:0] decode(input logic [7:0] code, input logic ext);
        logic [3:0] d;
        d = 4'hF;
        if (ext) begin
            if (code == 8'h5A) d = 4'hB;
        end else begin
            case (code)
                8'h45: d = 4'h0;
                8'h16: d = 4'h1;
                8'h1E: d = 4'h2;
                8'h26: d = 4'h3;
                8'h25: d = 4'h4;
                8'h2E: d = 4'h5;
                8'h36: d = 4'h6;
                8'h3D: d = 4'h7;
                8'h3E: d = 4'h8;
                8'h46: d = 4'h9;
                8'h5A: d = 4'hB;
                8'h0D: d = 4'hC;
                8'h66: d = 4'hD;
                default: d = 4'hF;
            endcase
        end
        return d;
    endfunction

    assign head      = mem[rd_ptr];
    assign key_valid = (fifo_count != '0);
    assign key_code  = key_valid ? head[7:0] : 8'h00;
    assign key_ext   = key_valid & head[9];
    assign key_break = key_valid & head[8];
    assign key_digit = key_valid ? decode(head[7:0], head[9]) : 4'hF;
    assign frame_err = frame_err_q & ~rst;
    assign overflow  = ovf_q & ~rst;

endmodule

// File: tb/tb_ps2_key_event_rx.sv
// Directed bench for ps2_key_event_rx: table of key events plus hand-written
// sequences for errors, overflow, timeout and mid-frame reset.
module tb_ps2_key_event_rx;

    localparam int H = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       key_ready = 1'b0;
    logic       key_valid, key_ext, key_break, frame_err, overflow;
    logic [7:0] key_code;
    logic [3:0] key_digit;
    logic [2:0] fifo_count;

    ps2_key_event_rx #(
        .CLK_DIV(1), .FILTER_LEN(2), .FIFO_DEPTH(4), .TIMEOUT_CYC(200)
    ) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .key_valid(key_valid), .key_ready(key_ready), .key_code(key_code),
        .key_ext(key_ext), .key_break(key_break), .key_digit(key_digit),
        .fifo_count(fifo_count), .frame_err(frame_err), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   err_cnt = 0, ovf_cnt = 0;
    int   n_cmp = 0, n_bad = 0;
    int   fall_cyc = -1000, lat = 0, rise_cyc = 0;
    logic valid_prev = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (frame_err) err_cnt++;
        if (overflow) ovf_cnt++;
        if (key_valid && !valid_prev) rise_cyc = cyc;
        valid_prev = key_valid;
    end

    typedef struct {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic [3:0] digit;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [10:0] frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic par;
        par = ~(^b) ^ bad_par;
        return {~bad_stop, par, b, 1'b0};
    endfunction

    // pa: raise key_ready exactly on the cycle the event from this frame is pushed
    task automatic step(input bit pa);
        @(negedge clk);
        if (pa) key_ready = (cyc == fall_cyc + lat - 1);
    endtask

    task automatic send_bits(input logic [10:0] b, input int n, input bit pa);
        for (int i = 0; i < n; i++) begin
            step(pa);
            ps2_data = b[i];
            repeat (H) step(pa);
            ps2_clk = 1'b0;
            if (i == 10) fall_cyc = cyc;
            repeat (H) step(pa);
            ps2_clk = 1'b1;
        end
        step(pa);
        ps2_data = 1'b1;
        repeat (12) step(pa);
        if (pa) key_ready = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        send_bits(frame(b, 1'b0, 1'b0), 11, 1'b0);
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        while (!key_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_valid"}, key_valid, 1);
    endtask

    task automatic pop();
        @(negedge clk);
        key_ready = 1'b1;
        @(negedge clk);
        key_ready = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_valid"}, key_valid, 0);
        chk({name, "_code"}, key_code, 0);
        chk({name, "_ext"}, key_ext, 0);
        chk({name, "_brk"}, key_break, 0);
        chk({name, "_digit"}, key_digit, 4'hF);
        chk({name, "_count"}, fifo_count, 0);
        chk({name, "_ferr"}, frame_err, 0);
        chk({name, "_ovf"}, overflow, 0);
    endtask

    initial begin
        int e0, o0;
        logic [7:0] exp_codes[4];

        vecs[0]  = '{8'h45, 1'b0, 1'b0, 4'h0};
        vecs[1]  = '{8'h1E, 1'b0, 1'b0, 4'h2};
        vecs[2]  = '{8'h26, 1'b0, 1'b0, 4'h3};
        vecs[3]  = '{8'h25, 1'b0, 1'b0, 4'h4};
        vecs[4]  = '{8'h2E, 1'b0, 1'b0, 4'h5};
        vecs[5]  = '{8'h36, 1'b0, 1'b0, 4'h6};
        vecs[6]  = '{8'h3D, 1'b0, 1'b0, 4'h7};
        vecs[7]  = '{8'h3E, 1'b0, 1'b0, 4'h8};
        vecs[8]  = '{8'h46, 1'b0, 1'b0, 4'h9};
        vecs[9]  = '{8'h5A, 1'b0, 1'b0, 4'hB};
        vecs[10] = '{8'h0D, 1'b0, 1'b0, 4'hC};
        vecs[11] = '{8'h66, 1'b0, 1'b0, 4'hD};
        vecs[12] = '{8'h1C, 1'b0, 1'b0, 4'hF};
        vecs[13] = '{8'h5A, 1'b1, 1'b0, 4'hB};
        vecs[14] = '{8'h45, 1'b1, 1'b0, 4'hF};
        vecs[15] = '{8'h45, 1'b0, 1'b1, 4'h0};
        vecs[16] = '{8'h5A, 1'b1, 1'b1, 4'hB};
        vecs[17] = '{8'h16, 1'b0, 1'b1, 4'h1};

        // reset state
        repeat (5) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // single event, then pop
        send(8'h16);
        wait_valid("ev16");
        lat = rise_cyc - fall_cyc;
        chk("ev16_code", key_code, 8'h16);
        chk("ev16_digit", key_digit, 4'h1);
        chk("ev16_ext", key_ext, 0);
        chk("ev16_brk", key_break, 0);
        chk("ev16_count", fifo_count, 1);
        pop();
        chk("ev16_pop_valid", key_valid, 0);
        chk("ev16_pop_digit", key_digit, 4'hF);
        chk("ev16_pop_count", fifo_count, 0);

        // table of key events, with optional E0/F0 prefixes
        for (int i = 0; i < 18; i++) begin
            if (vecs[i].ext) send(8'hE0);
            if (vecs[i].brk) send(8'hF0);
            send(vecs[i].code);
            wait_valid($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_count", i), fifo_count, 1);
            chk($sformatf("vec%0d_code", i), key_code, vecs[i].code);
            chk($sformatf("vec%0d_ext", i), key_ext, vecs[i].ext);
            chk($sformatf("vec%0d_brk", i), key_break, vecs[i].brk);
            chk($sformatf("vec%0d_digit", i), key_digit, vecs[i].digit);
            pop();
            chk($sformatf("vec%0d_empty", i), key_valid, 0);
        end

        // bad parity: error pulse, no event
        e0 = err_cnt;
        send_bits(frame(8'h16, 1'b1, 1'b0), 11, 1'b0);
        chk("badpar_err", err_cnt - e0, 1);
        chk("badpar_count", fifo_count, 0);

        // E0, bad stop, 5A: error clears the extended flag
        e0 = err_cnt;
        send(8'hE0);
        send_bits(frame(8'h66, 1'b0, 1'b1), 11, 1'b0);
        send(8'h5A);
        chk("badstop_err", err_cnt - e0, 1);
        wait_valid("badstop");
        chk("badstop_count", fifo_count, 1);
        chk("badstop_ext", key_ext, 0);
        chk("badstop_digit", key_digit, 4'hB);
        pop();

        // overflow on the fifth event
        o0 = ovf_cnt;
        send(8'h16); send(8'h1E); send(8'h26); send(8'h25);
        chk("fill_count", fifo_count, 4);
        chk("fill_no_ovf", ovf_cnt - o0, 0);
        send(8'h2E);
        chk("ovf_count", fifo_count, 4);
        chk("ovf_pulse", ovf_cnt - o0, 1);
        exp_codes[0] = 8'h16; exp_codes[1] = 8'h1E; exp_codes[2] = 8'h26; exp_codes[3] = 8'h25;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d_code", i), key_code, exp_codes[i]);
            pop();
        end
        chk("drain_empty", key_valid, 0);

        // full FIFO, pop in the same cycle as a push
        send(8'h16); send(8'h1E); send(8'h26); send(8'h25);
        o0 = ovf_cnt;
        send_bits(frame(8'h2E, 1'b0, 1'b0), 11, 1'b1);
        chk("pushpop_count", fifo_count, 4);
        chk("pushpop_no_ovf", ovf_cnt - o0, 0);
        exp_codes[0] = 8'h1E; exp_codes[1] = 8'h26; exp_codes[2] = 8'h25; exp_codes[3] = 8'h2E;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("pp_drain%0d_code", i), key_code, exp_codes[i]);
            pop();
        end
        chk("pp_drain_empty", key_valid, 0);

        // timeout after 4 data bits, then a normal frame
        e0 = err_cnt;
        send_bits(frame(8'h16, 1'b0, 1'b0), 5, 1'b0);
        repeat (260) @(negedge clk);
        chk("timeout_err", err_cnt - e0, 1);
        chk("timeout_valid", key_valid, 0);
        send(8'h3D);
        wait_valid("after_to");
        chk("after_to_code", key_code, 8'h3D);
        chk("after_to_digit", key_digit, 4'h7);
        chk("after_to_count", fifo_count, 1);
        pop();

        // reset mid-frame with two events queued
        send(8'h16); send(8'h1E);
        chk("prerst_count", fifo_count, 2);
        send_bits(frame(8'h36, 1'b0, 1'b0), 4, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs("midrst");
        rst = 1'b0;
        e0 = err_cnt;
        repeat (5) @(negedge clk);
        send(8'h0D);
        wait_valid("after_rst");
        chk("after_rst_digit", key_digit, 4'hC);
        chk("after_rst_count", fifo_count, 1);
        chk("after_rst_no_err", err_cnt - e0, 0);
        pop();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
